rf_wb_scheduler: RTL and testbench

//  Shares the single register-file write port between the in-order pipeline writeback
//  and the multi-cycle MUL/DIV unit (MDU). It keeps a per-register busy scoreboard for

---
 rtl/rf_wb_scheduler_if.sv | 63 ++++++
 rtl/rf_wb_scheduler.sv | 132 +++++++++++++
 tb/tb_rf_wb_scheduler.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_scheduler_if.sv
// Bundle of the scheduler's handshake and register-file write signals.
// The master side is the surrounding pipeline/MDU/Reg_File environment.
// The slave side is the scheduler itself.
interface rf_wb_scheduler_if #(
  parameter int DataWidth    = 32,
  parameter int AddrRegWidth = 5
);
  // Pipeline writeback request
  logic                         pipe_wb_valid;
  logic [AddrRegWidth-1:0]      pipe_wb_rd;
  logic [DataWidth-1:0]         pipe_wb_data;
  logic                         pipe_wb_ready;
  // MDU issue
  logic                         mdu_issue_valid;
  logic [AddrRegWidth-1:0]      mdu_issue_rd;
  logic                         mdu_issue_ready;
  // MDU result
  logic                         mdu_res_valid;
  logic [AddrRegWidth-1:0]      mdu_res_rd;
  logic [DataWidth-1:0]         mdu_res_data;
  logic                         mdu_res_ready;
  // Decode hazard query
  logic                         dec_valid;
  logic [AddrRegWidth-1:0]      dec_rs1;
  logic [AddrRegWidth-1:0]      dec_rs2;
  logic [AddrRegWidth-1:0]      dec_rd;
  logic                         dec_rs1_used;
  logic                         dec_rs2_used;
  logic                         dec_rd_used;
  logic                         hazard_stall;
  // Reg_File write port
  logic                         rf_writeEn;
  logic [AddrRegWidth-1:0]      rf_writeDataSel;
  logic [DataWidth-1:0]         rf_writeData;
  // Scoreboard view
  logic [(2**AddrRegWidth)-1:0] busy_mask;

  modport master (
    output pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
    input  pipe_wb_ready,
    output mdu_issue_valid, mdu_issue_rd,
    input  mdu_issue_ready,
    output mdu_res_valid, mdu_res_rd, mdu_res_data,
    input  mdu_res_ready,
    output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_rs1_used, dec_rs2_used, dec_rd_used,
    input  hazard_stall,
    input  rf_writeEn, rf_writeDataSel, rf_writeData,
    input  busy_mask
  );

  modport slave (
    input  pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
    output pipe_wb_ready,
    input  mdu_issue_valid, mdu_issue_rd,
    output mdu_issue_ready,
    input  mdu_res_valid, mdu_res_rd, mdu_res_data,
    output mdu_res_ready,
    input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_rs1_used, dec_rs2_used, dec_rd_used,
    output hazard_stall,
    output rf_writeEn, rf_writeDataSel, rf_writeData,
    output busy_mask
  );
endinterface

// File: rtl/rf_wb_scheduler.sv
// Register-file write-port scheduler.
// Arbitrates the single RF write port between the pipeline writeback and a one-entry
// MDU result hold buffer. A wait counter bounds how long the hold can be starved.
// A per-register busy scoreboard provides WAW issue protection and decode stalls.
module rf_wb_scheduler #(
  parameter int DataWidth    = 32,
  parameter int AddrRegWidth = 5,
  parameter int MaxWait      = 4
) (
  input  logic             brq_clk,
  input  logic             brq_rst,
  rf_wb_scheduler_if.slave bus
);
  localparam int NumRegs = 2 ** AddrRegWidth;
  localparam int WaitW   = $clog2(MaxWait + 1);
  localparam logic [WaitW-1:0]        MaxWaitC = WaitW'(MaxWait);
  localparam logic [WaitW-1:0]        WaitOne  = WaitW'(1);
  localparam logic [AddrRegWidth-1:0] RegZero  = {AddrRegWidth{1'b0}};

  // Architectural state
  logic                    hold_v_r;
  logic [AddrRegWidth-1:0] hold_rd_r;
  logic [DataWidth-1:0]    hold_data_r;
  logic [WaitW-1:0]        wait_cnt_r;
  logic [NumRegs-1:0]      busy_r;

  // Decisions for the current cycle
  logic                    starve_s;
  logic                    sel_hold_s;
  logic                    sel_pipe_s;
  logic                    accept_s;
  logic                    issue_fire_s;
  logic [NumRegs-1:0]      busy_nxt_s;
  logic                    stall_s;

  // Write-port grant: a starved hold beats the pipeline, otherwise the pipeline wins.
  always_comb begin
    starve_s   = hold_v_r && (wait_cnt_r == MaxWaitC);
    sel_hold_s = 1'b0;
    sel_pipe_s = 1'b0;
    if (starve_s) begin
      sel_hold_s = 1'b1;
    end else if (bus.pipe_wb_valid) begin
      sel_pipe_s = 1'b1;
    end else if (hold_v_r) begin
      sel_hold_s = 1'b1;
    end else begin
      sel_hold_s = 1'b0;
      sel_pipe_s = 1'b0;
    end
  end

  // Handshake qualifiers shared by the state update and the outputs.
  always_comb begin
    accept_s     = bus.mdu_res_valid && !hold_v_r;
    issue_fire_s = bus.mdu_issue_valid && !busy_r[bus.mdu_issue_rd];
  end

  // Next scoreboard: drain clears, issue sets afterwards so a same-index set wins.
  always_comb begin
    busy_nxt_s = busy_r;
    if (sel_hold_s) begin
      busy_nxt_s[hold_rd_r] = 1'b0;
    end else begin
      busy_nxt_s = busy_r;
    end
    if (issue_fire_s) begin
      busy_nxt_s[bus.mdu_issue_rd] = 1'b1;
    end else begin
      busy_nxt_s[bus.mdu_issue_rd] = busy_nxt_s[bus.mdu_issue_rd];
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Decode hazard: any used operand or destination with a pending MDU write.
  always_comb begin
    stall_s = bus.dec_valid &&
              ((bus.dec_rs1_used && busy_r[bus.dec_rs1]) ||
               (bus.dec_rs2_used && busy_r[bus.dec_rs2]) ||
               (bus.dec_rd_used  && busy_r[bus.dec_rd]));
  end

  // Hold buffer, starvation counter and scoreboard update.
  always_ff @(posedge brq_clk) begin
    if (brq_rst) begin
      hold_v_r    <= 1'b0;
      hold_rd_r   <= RegZero;
      hold_data_r <= {DataWidth{1'b0}};
      wait_cnt_r  <= {WaitW{1'b0}};
      busy_r      <= {NumRegs{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
      if (accept_s) begin
        hold_v_r    <= 1'b1;
        hold_rd_r   <= bus.mdu_res_rd;
        hold_data_r <= bus.mdu_res_data;
      end else if (sel_hold_s) begin
        hold_v_r    <= 1'b0;
      end else begin
        hold_v_r    <= hold_v_r;
      end
      if (!hold_v_r || sel_hold_s) begin
        wait_cnt_r <= {WaitW{1'b0}};
      end else if (sel_pipe_s && (wait_cnt_r != MaxWaitC)) begin
        wait_cnt_r <= wait_cnt_r + WaitOne;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end
  end

  // Output drive; reset forces a quiet port and open readies.
  always_comb begin
    bus.busy_mask       = busy_r;
    bus.rf_writeDataSel = sel_hold_s ? hold_rd_r   : bus.pipe_wb_rd;
    bus.rf_writeData    = sel_hold_s ? hold_data_r : bus.pipe_wb_data;
    if (brq_rst) begin
      bus.rf_writeEn      = 1'b0;
      bus.pipe_wb_ready   = 1'b1;
      bus.mdu_res_ready   = 1'b1;
      bus.mdu_issue_ready = 1'b1;
      bus.hazard_stall    = 1'b0;
    end else begin
      bus.rf_writeEn      = (sel_hold_s && (hold_rd_r != RegZero)) ||
                            (sel_pipe_s && (bus.pipe_wb_rd != RegZero));
      bus.pipe_wb_ready   = !starve_s;
      bus.mdu_res_ready   = !hold_v_r;
      bus.mdu_issue_ready = !busy_r[bus.mdu_issue_rd];
      bus.hazard_stall    = stall_s;
    end
  end
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Scoreboard bench for rf_wb_scheduler: directed stimulus pushes expected RF writes,
// a negedge monitor pops and compares every write the DUT presents.
module tb_rf_wb_scheduler;
  logic brq_clk = 1'b0;
  logic brq_rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [36:0] sb_q[$];

  always #5 brq_clk = ~brq_clk;

  rf_wb_scheduler_if #(.DataWidth(32), .AddrRegWidth(5)) bus();

  rf_wb_scheduler #(.DataWidth(32), .AddrRegWidth(5), .MaxWait(3)) dut (
    .brq_clk (brq_clk),
    .brq_rst (brq_rst),
    .bus     (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge brq_clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    sb_q.push_back({rd, data});
  endtask

  // Monitor: every RF write must match the oldest expected write.
  always @(negedge brq_clk) begin
    if (bus.rf_writeEn === 1'b1) begin
      logic [36:0] e;
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL rf_write_unexpected: got rd=%0d data=%0h expected no write",
                 bus.rf_writeDataSel, bus.rf_writeData);
      end else begin
        e = sb_q.pop_front();
        if ({bus.rf_writeDataSel, bus.rf_writeData} !== e) begin
          n_fail++;
          $display("FAIL rf_write: got rd=%0d data=%0h expected rd=%0d data=%0h",
                   bus.rf_writeDataSel, bus.rf_writeData, e[36:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    brq_rst = 1'b1;
    bus.pipe_wb_valid = 1'b0;  bus.pipe_wb_rd = 5'd0;  bus.pipe_wb_data = 32'd0;
    bus.mdu_issue_valid = 1'b0; bus.mdu_issue_rd = 5'd0;
    bus.mdu_res_valid = 1'b0;  bus.mdu_res_rd = 5'd0;  bus.mdu_res_data = 32'd0;
    bus.dec_valid = 1'b0; bus.dec_rs1 = 5'd0; bus.dec_rs2 = 5'd0; bus.dec_rd = 5'd0;
    bus.dec_rs1_used = 1'b0; bus.dec_rs2_used = 1'b0; bus.dec_rd_used = 1'b0;

    // 1. Reset and idle
    cyc(); cyc(); settle();
    chk("rst_wen", {63'd0, bus.rf_writeEn}, 64'd0);
    chk("rst_pipe_rdy", {63'd0, bus.pipe_wb_ready}, 64'd1);
    chk("rst_res_rdy", {63'd0, bus.mdu_res_ready}, 64'd1);
    brq_rst = 1'b0;
    cyc(); settle();
    chk("idle_mask", {32'd0, bus.busy_mask}, 64'd0);
    chk("idle_wen", {63'd0, bus.rf_writeEn}, 64'd0);
    chk("idle_issue_rdy", {63'd0, bus.mdu_issue_ready}, 64'd1);
    chk("idle_stall", {63'd0, bus.hazard_stall}, 64'd0);

    // 2. Issue rd=5, result three cycles later
    bus.mdu_issue_valid = 1'b1; bus.mdu_issue_rd = 5'd5;
    cyc(); bus.mdu_issue_valid = 1'b0; settle();
    chk("t2_busy_set", {32'd0, bus.busy_mask}, 64'h20);
    cyc(); cyc();
    bus.mdu_res_valid = 1'b1; bus.mdu_res_rd = 5'd5; bus.mdu_res_data = 32'hDEADBEEF;
    expect_wr(5'd5, 32'hDEADBEEF);
    settle();
    chk("t2_res_rdy", {63'd0, bus.mdu_res_ready}, 64'd1);
    chk("t2_no_wr_yet", {63'd0, bus.rf_writeEn}, 64'd0);
    cyc(); bus.mdu_res_valid = 1'b0; settle();
    chk("t2_wen", {63'd0, bus.rf_writeEn}, 64'd1);
    chk("t2_busy_held", {32'd0, bus.busy_mask}, 64'h20);
    chk("t2_res_busy", {63'd0, bus.mdu_res_ready}, 64'd0);
    cyc(); settle();
    chk("t2_busy_clr", {32'd0, bus.busy_mask}, 64'd0);
    chk("t2_wen_off", {63'd0, bus.rf_writeEn}, 64'd0);

    // 4. Decode hazard on reg3
    bus.mdu_issue_valid = 1'b1; bus.mdu_issue_rd = 5'd3;
    cyc(); bus.mdu_issue_valid = 1'b0;
    bus.dec_valid = 1'b1; bus.dec_rs1 = 5'd3; bus.dec_rs1_used = 1'b1;
    bus.dec_rs2 = 5'd1; bus.dec_rs2_used = 1'b1; bus.dec_rd = 5'd2; bus.dec_rd_used = 1'b1;
    settle();
    chk("t4_stall", {63'd0, bus.hazard_stall}, 64'd1);
    bus.dec_rs1_used = 1'b0; settle();
    chk("t4_unused", {63'd0, bus.hazard_stall}, 64'd0);
    bus.dec_rs1_used = 1'b1;
    bus.mdu_res_valid = 1'b1; bus.mdu_res_rd = 5'd3; bus.mdu_res_data = 32'h33;
    expect_wr(5'd3, 32'h33);
    cyc(); bus.mdu_res_valid = 1'b0; settle();
    chk("t4_stall_drain", {63'd0, bus.hazard_stall}, 64'd1);
    cyc(); settle();
    chk("t4_released", {63'd0, bus.hazard_stall}, 64'd0);
    bus.dec_valid = 1'b0;

    // 3. Starvation limit (MaxWait=3) against continuous pipeline writes
    bus.mdu_res_valid = 1'b1; bus.mdu_res_rd = 5'd9; bus.mdu_res_data = 32'h99;
    cyc(); bus.mdu_res_valid = 1'b0;
    bus.pipe_wb_valid = 1'b1; bus.pipe_wb_rd = 5'd7;
    for (int i = 0; i < 3; i++) begin
      bus.pipe_wb_data = 32'h700 + 32'(i);
      expect_wr(5'd7, 32'h700 + 32'(i));
      settle();
      chk("t3_pipe_rdy", {63'd0, bus.pipe_wb_ready}, 64'd1);
      cyc();
    end
    bus.pipe_wb_data = 32'h703;
    expect_wr(5'd9, 32'h99);
    settle();
    chk("t3_starve_rdy", {63'd0, bus.pipe_wb_ready}, 64'd0);
    chk("t3_starve_sel", {59'd0, bus.rf_writeDataSel}, 64'd9);
    expect_wr(5'd7, 32'h703);
    cyc(); settle();
    chk("t3_rdy_back", {63'd0, bus.pipe_wb_ready}, 64'd1);
    cyc(); bus.pipe_wb_valid = 1'b0; settle();
    chk("t3_idle", {63'd0, bus.rf_writeEn}, 64'd0);

    // 5. Register zero and WAW protection
    bus.mdu_issue_valid = 1'b1; bus.mdu_issue_rd = 5'd0;
    cyc(); bus.mdu_issue_valid = 1'b0; settle();
    chk("t5_rd0_mask", {32'd0, bus.busy_mask}, 64'd0);
    bus.mdu_res_valid = 1'b1; bus.mdu_res_rd = 5'd0; bus.mdu_res_data = 32'hAA;
    cyc(); bus.mdu_res_valid = 1'b0; settle();
    chk("t5_rd0_noweb", {63'd0, bus.rf_writeEn}, 64'd0);
    chk("t5_hold_full", {63'd0, bus.mdu_res_ready}, 64'd0);
    cyc(); settle();
    chk("t5_hold_freed", {63'd0, bus.mdu_res_ready}, 64'd1);
    bus.mdu_issue_valid = 1'b1; bus.mdu_issue_rd = 5'd4;
    cyc(); settle();
    chk("t5_busy4", {32'd0, bus.busy_mask}, 64'h10);
    chk("t5_waw_rdy", {63'd0, bus.mdu_issue_ready}, 64'd0);
    cyc(); bus.mdu_issue_valid = 1'b0; settle();
    chk("t5_mask_same", {32'd0, bus.busy_mask}, 64'h10);

    // 6. Reset with a loaded hold and busy[6]
    bus.mdu_issue_valid = 1'b1; bus.mdu_issue_rd = 5'd6;
    cyc(); bus.mdu_issue_valid = 1'b0;
    bus.pipe_wb_valid = 1'b1; bus.pipe_wb_rd = 5'd1; bus.pipe_wb_data = 32'h111;
    bus.mdu_res_valid = 1'b1; bus.mdu_res_rd = 5'd6; bus.mdu_res_data = 32'h66;
    expect_wr(5'd1, 32'h111);
    cyc(); bus.mdu_res_valid = 1'b0; bus.pipe_wb_valid = 1'b0;
    brq_rst = 1'b1; settle();
    chk("t6_busy_pre", {32'd0, bus.busy_mask}, 64'h50);
    chk("t6_rst_wen", {63'd0, bus.rf_writeEn}, 64'd0);
    cyc(); brq_rst = 1'b0; settle();
    chk("t6_mask_clr", {32'd0, bus.busy_mask}, 64'd0);
    chk("t6_hold_clr", {63'd0, bus.mdu_res_ready}, 64'd1);
    chk("t6_no_drain", {63'd0, bus.rf_writeEn}, 64'd0);
    cyc(); cyc(); settle();
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
